// File: rtl/rr_onehot_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package rr_onehot_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Pointer successor that wraps at num_req, including non-power-of-two sizes.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num_req);
    return (idx + 32'd1 >= num_req) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot (or zero) vector to binary index; an all-zero input yields 0.
module onehot_to_bin #(
  parameter int unsigned ONEHOT_WIDTH = 4,
  parameter int unsigned BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot_i[BIN_WIDTH'(i)]) begin
        bin_o = bin_o | BIN_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with one-hot and binary grant outputs.
// Define RR_ONEHOT_ARB_LOCK_EN to hold the grant stable while the downstream stalls.
module rr_onehot_arb
  import rr_onehot_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [NUM_REQ-1:0]   gnt_onehot_o,
  output logic [IDX_WIDTH-1:0] gnt_idx_o
);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   arb_gnt;

  // Cyclic search starting at ptr_q; first requester found wins.
  always_comb begin
    int unsigned pos;
    pos     = 0;
    arb_gnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (arb_gnt == '0 && req_i[IDX_WIDTH'(pos)]) begin
        arb_gnt[IDX_WIDTH'(pos)] = 1'b1;
      end
    end
  end

`ifdef RR_ONEHOT_ARB_LOCK_EN
  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;

  assign gnt_onehot_o = (state_q == LOCKED) ? lock_q : arb_gnt;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (flush_i) begin
      state_d = ARB;
      lock_d  = '0;
    end else begin
      unique case (state_q)
        ARB: begin
          if (valid_o && !ready_i) begin
            state_d = LOCKED;
            lock_d  = arb_gnt;
          end
        end
        LOCKED: begin
          if (ready_i) begin
            state_d = ARB;
            lock_d  = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  assign gnt_onehot_o = arb_gnt;
`endif

  assign valid_o = |gnt_onehot_o;
  assign gnt_o   = gnt_onehot_o & {NUM_REQ{ready_i}};

  onehot_to_bin #(
    .ONEHOT_WIDTH(NUM_REQ),
    .BIN_WIDTH   (IDX_WIDTH)
  ) u_onehot_to_bin (
    .onehot_i(gnt_onehot_o),
    .bin_o   (gnt_idx_o)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (valid_o && ready_i) begin
      ptr_d = IDX_WIDTH'(wrap_inc(32'(gnt_idx_o), NUM_REQ));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_onehot_o));
`ifdef RR_ONEHOT_ARB_LOCK_EN
  // A locked requester must keep requesting until its handshake completes.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCKED) |-> ((req_i & lock_q) == lock_q));
`endif
`endif

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Randomized and directed bench for rr_onehot_arb (NUM_REQ=4 and NUM_REQ=3 instances).
module tb_rr_onehot_arb;

`ifdef RR_ONEHOT_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, flush, ready;
  logic [3:0] req4, gnt4, oh4;
  logic       v4;
  logic [1:0] idx4;
  logic [2:0] req3, gnt3, oh3;
  logic       v3;
  logic [1:0] idx3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance (0: NUM_REQ=4, 1: NUM_REQ=3).
  int m_n[2] = '{4, 3};
  int m_ptr[2];
  int m_lk_idx[2];
  bit m_locked[2];
  int last_sel[2];

  always #5 clk = ~clk;

  rr_onehot_arb #(.NUM_REQ(4)) u_dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_i       (req4),
    .gnt_o       (gnt4),
    .valid_o     (v4),
    .ready_i     (ready),
    .gnt_onehot_o(oh4),
    .gnt_idx_o   (idx4)
  );

  rr_onehot_arb #(.NUM_REQ(3)) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_i       (req3),
    .gnt_o       (gnt3),
    .valid_o     (v3),
    .ready_i     (ready),
    .gnt_onehot_o(oh3),
    .gnt_idx_o   (idx3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected selected requester, or -1 when nothing is granted.
  function automatic int exp_sel(input int k, input logic [3:0] r);
    if (LockEn && m_locked[k]) return m_lk_idx[k];
    for (int off = 0; off < m_n[k]; off++) begin
      int i;
      i = (m_ptr[k] + off) % m_n[k];
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k]    = 0;
      m_locked[k] = 1'b0;
      m_lk_idx[k] = 0;
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [3:0] q4, input logic [2:0] q3,
                      input logic rd);
    int s;
    logic [31:0] oh;
    @(negedge clk);
    rst = r; flush = f; req4 = q4; req3 = q3; ready = rd;
    #1;
    if (r) model_reset();
    for (int k = 0; k < 2; k++) begin
      s  = exp_sel(k, (k == 0) ? q4 : {1'b0, q3});
      oh = (s < 0) ? 32'd0 : (32'd1 << s);
      last_sel[k] = s;
      if (k == 0) begin
        check_eq("onehot4", 32'(oh4), oh);
        check_eq("idx4", 32'(idx4), (s < 0) ? 32'd0 : 32'(s));
        check_eq("valid4", 32'(v4), 32'(s >= 0));
        check_eq("gnt4", 32'(gnt4), rd ? oh : 32'd0);
      end else begin
        check_eq("onehot3", 32'(oh3), oh);
        check_eq("idx3", 32'(idx3), (s < 0) ? 32'd0 : 32'(s));
        check_eq("valid3", 32'(v3), 32'(s >= 0));
        check_eq("gnt3", 32'(gnt3), rd ? oh : 32'd0);
      end
      if (!r) begin
        if (f) begin
          m_ptr[k]    = 0;
          m_locked[k] = 1'b0;
        end else if (s >= 0 && rd) begin
          m_ptr[k]    = (s + 1) % m_n[k];
          m_locked[k] = 1'b0;
        end else if (s >= 0 && LockEn) begin
          m_locked[k] = 1'b1;
          m_lk_idx[k] = s;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] pend4, q4;
    logic [2:0] pend3, q3;
    logic       rd, f;
    rst = 1'b1; flush = 1'b0; req4 = '0; req3 = '0; ready = 1'b0;
    model_reset();

    // Reset behaviour: requester 0 first; all-low gives all-zero outputs.
    step(1'b1, 1'b0, 4'b0000, 3'b000, 1'b1);
    step(1'b1, 1'b0, 4'b1010, 3'b111, 1'b1);
    step(1'b0, 1'b0, 4'b1010, 3'b111, 1'b1);
    step(1'b0, 1'b0, 4'b1010, 3'b111, 1'b1);

    // Full load: idx 0,1,2,3 repeating (and 0,1,2,0 on the 3-way instance).
    step(1'b0, 1'b1, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'b1111, 3'b111, 1'b1);

    // Stall, then a higher-priority requester arrives mid-stall.
    step(1'b0, 1'b1, 4'b0000, 3'b000, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 3'b100, 1'b0);
    step(1'b0, 1'b0, 4'b0100, 3'b100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0101, 3'b101, 1'b0);
    step(1'b0, 1'b0, 4'b0101, 3'b101, 1'b1);
    step(1'b0, 1'b0, 4'b0101, 3'b101, 1'b1);

    // Flush while stalled on requester 2 resets the pointer to 0.
    step(1'b0, 1'b1, 4'b0000, 3'b000, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 3'b111, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 3'b111, 1'b1);
    step(1'b0, 1'b0, 4'b0100, 3'b100, 1'b0);
    step(1'b0, 1'b1, 4'b0100, 3'b100, 1'b0);
    step(1'b0, 1'b0, 4'b0101, 3'b101, 1'b1);

    // Random traffic: requests held until granted, random stalls and flushes.
    pend4 = '0;
    pend3 = '0;
    for (int i = 0; i < 400; i++) begin
      q4 = pend4 | 4'($urandom_range(0, 15));
      q3 = pend3 | 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 2) != 0);
      f  = ($urandom_range(0, 40) == 0);
      step(1'b0, f, q4, q3, rd);
      pend4 = q4 & ~((last_sel[0] >= 0 && rd) ? 4'(1 << last_sel[0]) : 4'b0000);
      pend3 = q3 & ~((last_sel[1] >= 0 && rd) ? 3'(1 << last_sel[1]) : 3'b000);
    end

    // Mid-run reset returns to requester-0 priority.
    step(1'b1, 1'b0, 4'b1001, 3'b110, 1'b0);
    step(1'b0, 1'b0, 4'b1001, 3'b110, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arb.md
# rr_onehot_arb

Round-robin arbiter that shares one downstream valid/ready port among `NUM_REQ` requesters. It produces a one-hot grant vector and the equivalent binary grant index. Fairness comes from a registered priority pointer. The one-hot to binary conversion is done by the team's `onehot_to_bin` cell. The block sits in front of any shared resource that needs both a select vector and an index, for example a mux select or ID tagging.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 1; need not be a power of two.
- `IDX_WIDTH`, default `NUM_REQ == 1 ? 1 : $clog2(NUM_REQ)`: derived; do not override.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  synchronous clear of pointer and lock state.
- `req_i`  in  `NUM_REQ`  per-requester request (valid).
- `gnt_o`  out  `NUM_REQ`  per-requester handshake completion: `gnt_onehot_o & {NUM_REQ{ready_i}}`.
- `valid_o`  out  1  downstream valid; equals `|gnt_onehot_o`.
- `ready_i`  in  1  downstream ready.
- `gnt_onehot_o`  out  `NUM_REQ`  selected requester, one-hot or zero.
- `gnt_idx_o`  out  `IDX_WIDTH`  binary index of `gnt_onehot_o`; 0 when no grant.

## Operation
- Priority pointer `ptr_q` (`IDX_WIDTH` bits), reset value 0.
- Selection: the lowest index i, searching cyclically from `ptr_q` upward, with `req_i[i]` set. Indices wrap from `NUM_REQ-1` to 0.
- On handshake (`valid_o && ready_i`), `ptr_q` becomes granted index + 1. That value wraps to 0 when the index is `NUM_REQ-1`, including for non-power-of-two `NUM_REQ`.
- No handshake leaves `ptr_q` unchanged.
- FSM with states ARB and LOCKED; reset state is ARB.
  - ARB: grant is computed combinationally from `req_i` and `ptr_q`. If `valid_o && !ready_i`, the grant is captured into `lock_q` and the FSM goes to LOCKED.
  - LOCKED: `gnt_onehot_o = lock_q`, regardless of new or higher-priority requests. When `ready_i` is high, the handshake completes, `ptr_q` advances and the FSM returns to ARB.
- Requesters must hold `req_i` until their `gnt_o` bit is set. If a requester drops `req_i` while LOCKED, `valid_o` stays asserted; this is a protocol error.
- `flush_i`: next edge sets `ptr_q` to 0, clears `lock_q` and enters ARB. `flush_i` overrides a simultaneous handshake's pointer update. Outputs in the flush cycle are still combinational and normal.
- Reset values: `ptr_q` = 0, `lock_q` = 0, state ARB.
  - Outputs while reset is asserted follow `req_i` with `ptr_q` = 0, so requester 0 has highest priority.
  - With all `req_i` low, all outputs are 0.
- `NUM_REQ == 1`: `gnt_idx_o` is always 0, and `ptr_q` stays 0.

## Timing
- Request to `valid_o`/`gnt_onehot_o`/`gnt_idx_o`: 0 cycles, combinational in ARB.
- `ready_i` to `gnt_o`: 0 cycles, combinational.
- Pointer and lock updates: 1 cycle after the triggering edge condition.
- Back-to-back grants: one handshake per cycle is sustained with `ready_i` held high.

## Configuration
- `RR_ONEHOT_ARB_LOCK_EN`
  - Defined: the LOCKED state and `lock_q` are present, so the grant is stable while stalled. This is required for AXI-style downstream protocols.
  - Undefined: no LOCKED state and no `lock_q`. The grant is recomputed every cycle, so it may switch during a stall when a higher-priority request arrives. `ptr_q` behaviour is unchanged.

## Structure
- Shared package `rr_onehot_arb_pkg`:
  - `arb_state_e` enum with values ARB and LOCKED.
  - A function computing the wrapped increment for a given `NUM_REQ`.
- Sub-module: one instance of `onehot_to_bin` with `ONEHOT_WIDTH = NUM_REQ`, driving `gnt_idx_o`.
- Simulation assertions, skipped under `SYNTHESIS`:
  - `$onehot0(gnt_onehot_o)`.
  - No `req_i` drop of the locked requester while LOCKED.

## Test plan
- Reset with `NUM_REQ=4`, `req_i=4'b1010`, `ready_i=1` → `gnt_onehot_o=4'b0010`, `gnt_idx_o=1`; next cycle `ptr_q=2`, grant `4'b1000`, idx 3.
- `req_i=4'b1111` held, `ready_i=1` for 8 cycles → idx sequence 0,1,2,3,0,1,2,3.
- Stall, with `RR_ONEHOT_ARB_LOCK_EN`:
  - Stimulus: `req_i=4'b0100`, `ready_i=0`, then `req_i=4'b0101`.
  - Expected: grant stays `4'b0100` for every stall cycle; after `ready_i=1`, `gnt_o=4'b0100`, then the grant moves to requester 0.
- Same stall stimulus without the macro → grant switches to `4'b0001` in the cycle requester 0 asserts.
- `NUM_REQ=3`, all requesting, `ready_i=1` → idx 0,1,2,0; confirms the wrap from 2 to 0, and idx is never 3.
- `flush_i` while LOCKED at idx 2 → next cycle state ARB, `ptr_q=0`; with `req_i=4'b0101` the grant is `4'b0001`.
